// File: rtl/xpb_reduce_sequencer.sv
// Time-multiplexed XPB reduction: one segment per cycle through a shared table port, summed onto a base value.
// Optional build macro XPB_SKIP_ZERO_EN: visit only nonzero segments (a zero entry contributes nothing).
module xpb_reduce_sequencer #(
  parameter int SEG_BITS = 5,
  parameter int NUM_SEGS = 8,
  parameter int DATA_W   = 1024,
  parameter int SEL_W    = $clog2(NUM_SEGS),
  parameter int ACC_W    = DATA_W + $clog2(NUM_SEGS) + 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [NUM_SEGS*SEG_BITS-1:0] in_upper,
  input  logic [DATA_W-1:0]            in_base,
  output logic                         busy,
  output logic                         lut_req,
  output logic [SEL_W-1:0]             lut_sel,
  output logic [SEG_BITS-1:0]          lut_idx,
  input  logic [DATA_W-1:0]            lut_data,
  output logic                         done,
  output logic [ACC_W-1:0]             result
);

  localparam int UP_W = NUM_SEGS * SEG_BITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [UP_W-1:0]      seg_q, seg_d;
  logic [ACC_W-1:0]     acc_q, acc_d, acc_sum, res_q, res_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [SEG_BITS-1:0]  idx_q, idx_d;
`ifdef XPB_SKIP_ZERO_EN
  logic [NUM_SEGS-1:0]  mask_q, mask_d, nz;
`endif

  function automatic logic [SEG_BITS-1:0] seg_of(input logic [UP_W-1:0] v,
                                                 input logic [SEL_W-1:0] sel);
    seg_of = '0;
    for (int unsigned k = 0; k < NUM_SEGS; k++)
      if (SEL_W'(k) == sel) seg_of = v[k*SEG_BITS +: SEG_BITS];
  endfunction

`ifdef XPB_SKIP_ZERO_EN
  function automatic logic [NUM_SEGS-1:0] nz_mask(input logic [UP_W-1:0] v);
    for (int unsigned k = 0; k < NUM_SEGS; k++)
      nz_mask[k] = |v[k*SEG_BITS +: SEG_BITS];
  endfunction

  // Descending scan so the last hit is the lowest set bit.
  function automatic logic [SEL_W-1:0] first_set(input logic [NUM_SEGS-1:0] m);
    first_set = '0;
    for (int unsigned k = NUM_SEGS; k > 0; k--)
      if (m[k-1]) first_set = SEL_W'(k-1);
  endfunction
`endif

  assign acc_sum = acc_q + {{(ACC_W-DATA_W){1'b0}}, lut_data};

  always_comb begin
    state_d = state_q;
    seg_d   = seg_q;
    acc_d   = acc_q;
    res_d   = res_q;
    sel_d   = sel_q;
    idx_d   = idx_q;
`ifdef XPB_SKIP_ZERO_EN
    mask_d  = mask_q;
    nz      = nz_mask(in_upper);
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          seg_d = in_upper;
          acc_d = {{(ACC_W-DATA_W){1'b0}}, in_base};
`ifdef XPB_SKIP_ZERO_EN
          if (nz == '0) begin
            state_d = DONE;
            res_d   = {{(ACC_W-DATA_W){1'b0}}, in_base};
          end else begin
            state_d = RUN;
            sel_d   = first_set(nz);
            idx_d   = seg_of(in_upper, sel_d);
            mask_d  = nz & ~(NUM_SEGS'(1) << sel_d);
          end
`else
          state_d = RUN;
          sel_d   = '0;
          idx_d   = in_upper[SEG_BITS-1:0];
`endif
        end
      end
      RUN: begin
        acc_d = acc_sum;
        // lut_sel/lut_idx are preloaded one edge early so the table port sees registers only.
`ifdef XPB_SKIP_ZERO_EN
        if (mask_q == '0) begin
          state_d = DONE;
          res_d   = acc_sum;
          sel_d   = '0;
          idx_d   = '0;
        end else begin
          sel_d  = first_set(mask_q);
          idx_d  = seg_of(seg_q, sel_d);
          mask_d = mask_q & ~(NUM_SEGS'(1) << sel_d);
        end
`else
        if (sel_q == SEL_W'(NUM_SEGS-1)) begin
          state_d = DONE;
          res_d   = acc_sum;
          sel_d   = '0;
          idx_d   = '0;
        end else begin
          sel_d = sel_q + 1'b1;
          idx_d = seg_of(seg_q, sel_d);
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      seg_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      sel_q   <= '0;
      idx_q   <= '0;
`ifdef XPB_SKIP_ZERO_EN
      mask_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      seg_q   <= seg_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
`ifdef XPB_SKIP_ZERO_EN
      mask_q  <= mask_d;
`endif
    end
  end

  assign busy    = (state_q != IDLE);
  assign lut_req = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign lut_sel = sel_q;
  assign lut_idx = idx_q;
  assign result  = res_q;

endmodule

// File: tb/tb_xpb_reduce_sequencer.sv
// Scoreboard bench for xpb_reduce_sequencer: random golden tables, reference sums and visit order queued at issue time.
// Honours XPB_SKIP_ZERO_EN when the design is built with it.
module tb_xpb_reduce_sequencer;

  localparam int SEG_BITS = 5;
  localparam int NUM_SEGS = 8;
  localparam int DATA_W   = 1024;
  localparam int SEL_W    = 3;
  localparam int ACC_W    = DATA_W + 3 + 1;
  localparam int UP_W     = NUM_SEGS * SEG_BITS;
  localparam int TBL_N    = 1 << SEG_BITS;

  logic               clk = 1'b0;
  logic               rst_n, start;
  logic [UP_W-1:0]    in_upper;
  logic [DATA_W-1:0]  in_base, lut_data;
  logic               busy, lut_req, done;
  logic [SEL_W-1:0]   lut_sel;
  logic [SEG_BITS-1:0] lut_idx;
  logic [ACC_W-1:0]   result;

  logic [DATA_W-1:0]  tbl [NUM_SEGS][TBL_N];

  logic [ACC_W-1:0]            exp_res_q[$];
  int                          exp_cyc_q[$];
  logic [SEL_W+SEG_BITS-1:0]   exp_visit_q[$];

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  int busy_until = -1;

  xpb_reduce_sequencer #(
    .SEG_BITS(SEG_BITS), .NUM_SEGS(NUM_SEGS), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_upper(in_upper), .in_base(in_base),
    .busy(busy), .lut_req(lut_req), .lut_sel(lut_sel), .lut_idx(lut_idx),
    .lut_data(lut_data), .done(done), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always_comb lut_data = tbl[lut_sel][lut_idx];

  task automatic chk(input string name, input logic [ACC_W-1:0] act, input logic [ACC_W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got top/low %h_%h, expected %h_%h", name, cyc,
               act[ACC_W-1:ACC_W-64], act[127:0], exp[ACC_W-1:ACC_W-64], exp[127:0]);
    end
  endtask

  function automatic logic [DATA_W-1:0] rand_wide();
    logic [DATA_W-1:0] v;
    for (int w = 0; w < DATA_W/32; w++) v[w*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [ACC_W-1:0] ref_sum(input logic [UP_W-1:0] up, input logic [DATA_W-1:0] base);
    logic [ACC_W-1:0] s = ACC_W'(base);
    for (int k = 0; k < NUM_SEGS; k++) s += ACC_W'(tbl[k][up[k*SEG_BITS +: SEG_BITS]]);
    return s;
  endfunction

  // Called at a negedge; start is sampled by the following rising edge.
  task automatic issue(input logic [UP_W-1:0] up, input logic [DATA_W-1:0] base);
    int nnz = 0, lat;
    logic [SEG_BITS-1:0] s;
    in_upper = up;
    in_base  = base;
    start    = 1'b1;
    if (cyc > busy_until) begin
      for (int k = 0; k < NUM_SEGS; k++) begin
        s = up[k*SEG_BITS +: SEG_BITS];
        if (s != 0) nnz++;
`ifdef XPB_SKIP_ZERO_EN
        if (s != 0) exp_visit_q.push_back({SEL_W'(k), s});
`else
        exp_visit_q.push_back({SEL_W'(k), s});
`endif
      end
`ifdef XPB_SKIP_ZERO_EN
      lat = nnz + 1;
`else
      lat = NUM_SEGS + 1;
`endif
      exp_res_q.push_back(ref_sum(up, base));
      exp_cyc_q.push_back(cyc + lat);
      busy_until = cyc + lat;
    end
    @(posedge clk);
    #1;
    start    = 1'b0;
    in_upper = UP_W'({$urandom, $urandom});
    in_base  = rand_wide();
  endtask

  task automatic go_neg(input int target);
    int g = 0;
    while (cyc != target && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("go_neg_reached", ACC_W'(cyc), ACC_W'(target));
  endtask

  task automatic wait_idle();
    @(negedge clk);
    while (cyc <= busy_until) @(negedge clk);
  endtask

  // Monitor: consumes expected table visits and results as the DUT presents them.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (lut_req) begin
        if (exp_visit_q.size() == 0) chk("unexpected_lut_req", 1, 0);
        else chk("lut_sel_idx", ACC_W'({lut_sel, lut_idx}), ACC_W'(exp_visit_q.pop_front()));
      end else begin
        chk("lut_idle_zero", ACC_W'({lut_sel, lut_idx}), '0);
      end
      if (done) begin
        if (exp_res_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          chk("result", result, exp_res_q.pop_front());
          chk("done_cycle", ACC_W'(cyc), ACC_W'(exp_cyc_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [UP_W-1:0] up;
    int e;
    for (int k = 0; k < NUM_SEGS; k++) begin
      tbl[k][0] = '0;
      for (int i = 1; i < TBL_N; i++) tbl[k][i] = rand_wide();
      tbl[k][TBL_N-1] = '1;
    end

    // Reset held with start asserted.
    rst_n = 1'b0; start = 1'b1; in_upper = '1; in_base = rand_wide();
    repeat (3) @(negedge clk);
    chk("rst_busy", ACC_W'(busy), 0);
    chk("rst_lut_req", ACC_W'(lut_req), 0);
    chk("rst_lut_sel", ACC_W'(lut_sel), 0);
    chk("rst_lut_idx", ACC_W'(lut_idx), 0);
    chk("rst_done", ACC_W'(done), 0);
    chk("rst_result", result, 0);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    busy_until = cyc;
    repeat (3) @(negedge clk);

    // Directed: all-zero segments, single segment, all-max with all-ones base.
    issue('0, DATA_W'(5));
    wait_idle();
    issue(UP_W'(1), '0);
    wait_idle();
    issue('1, '1);
    wait_idle();

    // Starts in cycles 3 and 9 of an op are ignored; cycle 10 is accepted.
    up = UP_W'({$urandom, $urandom});
    e = cyc + 1;
    issue(up, rand_wide());
    go_neg(e + 2);
    issue(UP_W'({$urandom, $urandom}), rand_wide());
`ifdef XPB_SKIP_ZERO_EN
    wait_idle();
    e = cyc + 1;
    issue('1, rand_wide());
`endif
    go_neg(e + 8);
    issue(UP_W'({$urandom, $urandom}), rand_wide());
    go_neg(e + 9);
    issue(UP_W'({$urandom, $urandom}), rand_wide());
    wait_idle();

    // Reset during RUN aborts silently; a following op completes.
    e = cyc + 1;
    issue('1, rand_wide());
    go_neg(e + 3);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", ACC_W'(busy), 0);
    chk("abort_lut_req", ACC_W'(lut_req), 0);
    chk("abort_done", ACC_W'(done), 0);
    chk("abort_result", result, 0);
    exp_res_q.delete();
    exp_cyc_q.delete();
    exp_visit_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    busy_until = cyc;
    @(negedge clk);
    issue(UP_W'({$urandom, $urandom}), rand_wide());
    wait_idle();

    // Random ops: sparse segments, random gaps, occasional start while busy.
    for (int n = 0; n < 30; n++) begin
      for (int k = 0; k < NUM_SEGS; k++)
        up[k*SEG_BITS +: SEG_BITS] = ($urandom_range(2) == 0) ? '0 : SEG_BITS'($urandom);
      repeat ($urandom_range(2)) @(negedge clk);
      issue(up, rand_wide());
      if ($urandom_range(3) == 0) begin
        @(negedge clk);
        issue(UP_W'({$urandom, $urandom}), rand_wide());
      end
      wait_idle();
    end

    repeat (3) @(negedge clk);
    chk("pending_results", ACC_W'(exp_res_q.size()), 0);
    chk("pending_visits", ACC_W'(exp_visit_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
